flash_arbiter: RTL and testbench

//  Shares the single spi_flash port (adr/dat/we/stb/tga -> dat/ack/rty) between N_REQ requesters
//  (e.g. preset loader, settings writer). Round-robin grant; retries automatically on flash busy (rty).

---
 rtl/flash_pkg.sv | 22 ++
 rtl/flash_rr_pick.sv | 40 ++++
 rtl/flash_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_flash_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared types and constants for the SPI flash arbiter and its round-robin picker.
package flash_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BUS,
      DONE,
      GAP,
      BACKOFF
   } arb_state_e;

   typedef struct packed {
      logic [23:0] adr;
      logic [31:0] dat;
      logic        we;
      logic        tga;
   } flash_req_t;

   // The flash needs at least this many stb-low cycles to fall back to its idle state.
   localparam int MIN_GAP = 6;

endpackage

// File: rtl/flash_rr_pick.sv
// Combinational round-robin selector. ptr is the requester that has top priority this
// cycle; the search wraps from ptr up to N_REQ-1 and then from 0 up to ptr-1.
module flash_rr_pick #(
   parameter int N_REQ = 2,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx,
   output logic             valid
);

   logic [N_REQ-1:0] rot;
   logic [N_REQ-1:0] rot_hot;
   logic [IW:0]      rot_idx;
   logic [IW:0]      sum;

   // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the one-hot back.
   always_comb begin
      rot     = N_REQ'({req, req} >> ptr);
      rot_hot = '0;
      rot_idx = '0;
      valid   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!valid && rot[i]) begin
            valid      = 1'b1;
            rot_hot[i] = 1'b1;
            rot_idx    = (IW+1)'(i);
         end
      end
      grant = N_REQ'(({rot_hot, rot_hot} << ptr) >> N_REQ);
      sum   = rot_idx + {1'b0, ptr};
      if (sum >= (IW+1)'(N_REQ)) begin
         sum = sum - (IW+1)'(N_REQ);
      end
      idx = IW'(sum);
   end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one spi_flash port between N_REQ requesters. Round-robin grant, automatic
// reissue after flash busy (rty), per-attempt watchdog, and a guaranteed stb-low gap
// after every transaction so the flash returns to its idle state.
module flash_arbiter
   import flash_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int GAP_CYCLES     = 16,
   parameter int RETRY_DLY      = 4096,
   parameter int MAX_RETRY      = 8,
   parameter int TIMEOUT_CYCLES = 150_000_000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_REQ-1:0]    req_stb_i,
   input  logic [N_REQ-1:0]    req_we_i,
   input  logic [N_REQ-1:0]    req_tga_i,
   input  logic [N_REQ*24-1:0] req_adr_i,
   input  logic [N_REQ*32-1:0] req_dat_i,
   output logic [N_REQ-1:0]    req_ack_o,
   output logic [N_REQ-1:0]    req_err_o,
   output logic [31:0]         req_dat_o,
   output logic [23:0]         adr_o,
   output logic [31:0]         dat_o,
   output logic                we_o,
   output logic                tga_o,
   output logic                stb_o,
   input  logic [31:0]         dat_i,
   input  logic                ack_i,
   input  logic                rty_i
);

   localparam int IW    = $clog2(N_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DLY_W = $clog2(RETRY_DLY + 1);
   localparam int RC_W  = $clog2(MAX_RETRY + 1);

   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DLY_W-1:0] GAP_LAST = DLY_W'(GAP_CYCLES - 1);
   localparam logic [DLY_W-1:0] BO_LAST  = DLY_W'(RETRY_DLY - 1);
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(MAX_RETRY - 1);
   localparam logic [IW-1:0]    IDX_LAST = IW'(N_REQ - 1);

   // Reject parameter sets that would cut the flash idle gap short.
   if (!(RETRY_DLY >= GAP_CYCLES && GAP_CYCLES >= MIN_GAP)) begin : g_bad_timing
      $error("flash_arbiter: RETRY_DLY >= GAP_CYCLES >= MIN_GAP is required");
   end
   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("flash_arbiter: N_REQ must be in 2..8");
   end

   arb_state_e       state;
   arb_state_e       state_next;
   logic [IW-1:0]    ptr;
   logic [N_REQ-1:0] gnt_hot;
   flash_req_t       cur;
   logic [RC_W-1:0]  retry_cnt;
   logic [WD_W-1:0]  wd_cnt;
   logic [DLY_W-1:0] dly_cnt;
   logic             abandoned;
   logic             err_pend;
   logic             bus_err;
   logic             req_live;

   logic [N_REQ-1:0] pick_grant;
   logic [IW-1:0]    pick_idx;
   logic             pick_valid;
   flash_req_t       pick_req;

   flash_rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req   (req_stb_i),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign req_live = |(req_stb_i & gnt_hot);

   // Gather the winning requester's command fields out of the packed input buses.
   always_comb begin
      pick_req = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_grant[k]) begin
            pick_req.adr = req_adr_i[24*k +: 24];
            pick_req.dat = req_dat_i[32*k +: 32];
            pick_req.we  = req_we_i[k];
            pick_req.tga = req_tga_i[k];
         end
      end
   end

   // Next-state logic; ack beats a simultaneous rty, and an err always routes through GAP.
   always_comb begin
      state_next = state;
      bus_err    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_next = BUS;
            end
         end
         BUS: begin
            if (ack_i) begin
               state_next = DONE;
            end else if (rty_i) begin
               if (retry_cnt == RC_LAST) begin
                  bus_err    = 1'b1;
                  state_next = GAP;
               end else begin
                  state_next = BACKOFF;
               end
            end else if (wd_cnt == WD_LAST) begin
               bus_err    = 1'b1;
               state_next = GAP;
            end
         end
         DONE: begin
            state_next = GAP;
         end
         GAP: begin
            if (dly_cnt == GAP_LAST) begin
               state_next = IDLE;
            end
         end
         BACKOFF: begin
            if (dly_cnt == BO_LAST) begin
               state_next = BUS;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register plus the latched request, counters and abandon/err bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt_hot   <= '0;
         cur       <= '0;
         retry_cnt <= '0;
         wd_cnt    <= '0;
         dly_cnt   <= '0;
         abandoned <= 1'b0;
         err_pend  <= 1'b0;
         req_dat_o <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  cur       <= pick_req;
                  gnt_hot   <= pick_grant;
                  ptr       <= (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
                  retry_cnt <= '0;
                  wd_cnt    <= '0;
                  dly_cnt   <= '0;
                  abandoned <= 1'b0;
                  err_pend  <= 1'b0;
               end
            end
            BUS: begin
               if (wd_cnt != '1) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
               if (!req_live) begin
                  abandoned <= 1'b1;
               end
               if (ack_i) begin
                  req_dat_o <= dat_i;
               end else if (rty_i && retry_cnt != '1) begin
                  retry_cnt <= retry_cnt + 1'b1;
               end
               dly_cnt  <= '0;
               err_pend <= bus_err;
            end
            DONE: begin
               dly_cnt <= DLY_W'(1);
            end
            GAP: begin
               if (dly_cnt != '1) begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
               err_pend <= 1'b0;
            end
            BACKOFF: begin
               if (dly_cnt != '1) begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
               wd_cnt <= '0;
               if (!req_live) begin
                  abandoned <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign stb_o     = (state == BUS);
   assign adr_o     = cur.adr;
   assign dat_o     = cur.dat;
   assign we_o      = cur.we;
   assign tga_o     = cur.tga;
   assign req_ack_o = (state == DONE && !abandoned) ? gnt_hot : '0;
   assign req_err_o = (state == GAP && err_pend && !abandoned) ? gnt_hot : '0;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a behavioural flash that answers ack/rty
// after a programmable number of stb-high cycles.
module tb_flash_arbiter;

   localparam int GAP  = 16;
   localparam int RDLY = 4096;
   localparam int TMO  = 1000;

   logic        clk_i;
   logic        rst_i;
   logic [1:0]  req_stb;
   logic [1:0]  req_we;
   logic [1:0]  req_tga;
   logic [47:0] req_adr;
   logic [63:0] req_dat;
   logic [1:0]  req_ack_o;
   logic [1:0]  req_err_o;
   logic [31:0] req_dat_o;
   logic [23:0] adr_o;
   logic [31:0] dat_o;
   logic        we_o;
   logic        tga_o;
   logic        stb_o;
   logic [31:0] dat_i;
   logic        ack_i;
   logic        rty_i;

   int errors = 0;
   int checks = 0;

   int          m_dly = 40;
   int          m_rty_n = 0;
   bit          m_silent = 0;
   logic [31:0] m_data = 32'h0;
   int          hi_cnt;
   int          rty_given;

   bit mon_clr = 0;
   bit prev_stb;
   int windows, hi_len, low_len, min_low, last_hi, ack0, ack1, err0, err1;

   bit          cap;
   logic [23:0] cap_adr;
   logic [31:0] cap_dat;
   logic        cap_we;
   logic        cap_tga;
   logic [31:0] cap_rdat;

   flash_arbiter #(
      .N_REQ          (2),
      .GAP_CYCLES     (GAP),
      .RETRY_DLY      (RDLY),
      .MAX_RETRY      (8),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_stb_i (req_stb),
      .req_we_i  (req_we),
      .req_tga_i (req_tga),
      .req_adr_i (req_adr),
      .req_dat_i (req_dat),
      .req_ack_o (req_ack_o),
      .req_err_o (req_err_o),
      .req_dat_o (req_dat_o),
      .adr_o     (adr_o),
      .dat_o     (dat_o),
      .we_o      (we_o),
      .tga_o     (tga_o),
      .stb_o     (stb_o),
      .dat_i     (dat_i),
      .ack_i     (ack_i),
      .rty_i     (rty_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Flash model: after m_dly stb-high cycles answer rty (first m_rty_n times) then ack.
   always @(posedge clk_i) begin
      if (rst_i) begin
         ack_i     <= 1'b0;
         rty_i     <= 1'b0;
         dat_i     <= 32'h0;
         hi_cnt    <= 0;
         rty_given <= 0;
      end else begin
         ack_i <= 1'b0;
         rty_i <= 1'b0;
         if (!stb_o) begin
            hi_cnt <= 0;
         end else if (!ack_i && !rty_i && !m_silent) begin
            if (hi_cnt >= m_dly - 1) begin
               hi_cnt <= 0;
               if (rty_given < m_rty_n) begin
                  rty_i     <= 1'b1;
                  rty_given <= rty_given + 1;
               end else begin
                  ack_i <= 1'b1;
                  dat_i <= m_data;
               end
            end else begin
               hi_cnt <= hi_cnt + 1;
            end
         end
      end
   end

   // Bus monitor: stb windows, high/low lengths and pulse counts.
   always @(negedge clk_i) begin
      if (mon_clr) begin
         windows = 0; hi_len = 0; low_len = 0; min_low = 1000000000; last_hi = 0;
         ack0 = 0; ack1 = 0; err0 = 0; err1 = 0; prev_stb = 1'b0;
      end else begin
         if (stb_o) begin
            if (!prev_stb) begin
               if (windows > 0 && low_len < min_low) min_low = low_len;
               windows = windows + 1;
               hi_len = 0;
            end
            hi_len = hi_len + 1;
         end else begin
            if (prev_stb) begin
               last_hi = hi_len;
               low_len = 0;
            end
            low_len = low_len + 1;
         end
         prev_stb = stb_o;
         ack0 = ack0 + int'(req_ack_o[0]);
         ack1 = ack1 + int'(req_ack_o[1]);
         err0 = err0 + int'(req_err_o[0]);
         err1 = err1 + int'(req_err_o[1]);
      end
   end

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk_i);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      req_stb = '0; req_we = '0; req_tga = '0; req_adr = '0; req_dat = '0;
      m_silent = 1'b0; m_rty_n = 0; m_dly = 40;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      clear_mon();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_done(input int k, input int budget, output bit got_ack, output bit got_err,
                            output logic [1:0] ack_vec, output logic [1:0] err_vec);
      got_ack = 0; got_err = 0; ack_vec = '0; err_vec = '0; cap = 0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk_i);
         #1;
         if (stb_o && !cap) begin
            cap = 1; cap_adr = adr_o; cap_dat = dat_o; cap_we = we_o; cap_tga = tga_o;
         end
         if (req_ack_o != 2'b00 || req_err_o != 2'b00) begin
            got_ack = req_ack_o[k]; got_err = req_err_o[k];
            ack_vec = req_ack_o; err_vec = req_err_o; cap_rdat = req_dat_o;
            req_stb[k] = 1'b0;
            break;
         end
      end
   endtask

   task automatic serve(input logic [1:0] mask, output int first, output int second, output bit ok);
      int n;
      n = 0; first = -1; second = -1; ok = 0;
      req_stb = mask;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk_i);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (req_stb[k] && req_ack_o[k]) begin
               if (n == 0) first = k; else second = k;
               n = n + 1;
               req_stb[k] = 1'b0;
            end
         end
         if (req_stb == 2'b00) begin
            ok = 1;
            break;
         end
      end
      req_stb = '0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      req_stb = '0; req_we = '0; req_tga = '0; req_adr = '0; req_dat = '0;
      repeat (3) @(posedge clk_i);
      #1;
      checks++; if (stb_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stb: got %b expected 0", stb_o); end
      checks++; if (req_ack_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 00", req_ack_o); end
      checks++; if (req_err_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_err: got %b expected 00", req_err_o); end
      checks++; if (req_dat_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdat: got %h expected 0", req_dat_o); end
      checks++; if ({adr_o, we_o, tga_o} !== 26'h0) begin errors++; $display("[TB] FAIL reset_bus: got %h expected 0", {adr_o, we_o, tga_o}); end
      rst_i = 1'b0;
   endtask

   task automatic test_read();
      bit ga, ge; logic [1:0] av, ev;
      do_reset();
      m_dly = 40; m_data = 32'hDEADBEEF;
      req_adr[23:0] = 24'h000100; req_stb[0] = 1'b1;
      wait_done(0, 500, ga, ge, av, ev);
      checks++; if (ga !== 1'b1) begin errors++; $display("[TB] FAIL read_ack: got %b expected 1", ga); end
      checks++; if (av !== 2'b01 || ev !== 2'b00) begin errors++; $display("[TB] FAIL read_pulse: got ack=%b err=%b expected 01/00", av, ev); end
      checks++; if (cap_rdat !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected deadbeef", cap_rdat); end
      checks++; if (cap_adr !== 24'h000100 || cap_we !== 1'b0) begin errors++; $display("[TB] FAIL read_adr: got %h we=%b expected 000100 we=0", cap_adr, cap_we); end
      @(posedge clk_i);
      #1;
      m_data = 32'hCAFEF00D;
      req_adr[23:0] = 24'h000200; req_dat[31:0] = 32'h12345678; req_we[0] = 1'b1; req_stb[0] = 1'b1;
      wait_done(0, 500, ga, ge, av, ev);
      checks++; if (ga !== 1'b1) begin errors++; $display("[TB] FAIL write_ack: got %b expected 1", ga); end
      checks++; if (cap_dat !== 32'h12345678 || cap_we !== 1'b1) begin errors++; $display("[TB] FAIL write_bus: got %h we=%b expected 12345678 we=1", cap_dat, cap_we); end
      checks++; if (cap_rdat !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL write_rdat: got %h expected cafef00d", cap_rdat); end
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (windows !== 2 || ack0 !== 2 || err0 !== 0) begin errors++; $display("[TB] FAIL read_counts: got win=%0d ack=%0d err=%0d expected 2/2/0", windows, ack0, err0); end
      checks++; if (min_low < GAP) begin errors++; $display("[TB] FAIL read_gap: got %0d expected >= %0d", min_low, GAP); end
   endtask

   task automatic test_rr();
      int f, s; bit ok;
      do_reset();
      m_dly = 10; m_data = 32'h11112222;
      req_adr = {24'h000020, 24'h000010};
      serve(2'b11, f, s, ok);
      checks++; if (!ok || f !== 0 || s !== 1) begin errors++; $display("[TB] FAIL rr_first: got ok=%0d order=%0d,%0d expected 1 0,1", ok, f, s); end
      serve(2'b01, f, s, ok);
      checks++; if (!ok || f !== 0) begin errors++; $display("[TB] FAIL rr_single: got ok=%0d first=%0d expected 1 0", ok, f); end
      serve(2'b11, f, s, ok);
      checks++; if (!ok || f !== 1 || s !== 0) begin errors++; $display("[TB] FAIL rr_rotate: got ok=%0d order=%0d,%0d expected 1 1,0", ok, f, s); end
   endtask

   task automatic test_retry();
      bit ga, ge; logic [1:0] av, ev;
      do_reset();
      m_dly = 20; m_rty_n = 2; m_data = 32'h0000A5A5;
      req_adr[23:0] = 24'h000300; req_stb[0] = 1'b1;
      wait_done(0, 20000, ga, ge, av, ev);
      checks++; if (ga !== 1'b1 || ge !== 1'b0) begin errors++; $display("[TB] FAIL retry_done: got ack=%b err=%b expected 1/0", ga, ge); end
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (windows !== 3) begin errors++; $display("[TB] FAIL retry_windows: got %0d expected 3", windows); end
      checks++; if (min_low < RDLY) begin errors++; $display("[TB] FAIL retry_backoff: got %0d expected >= %0d", min_low, RDLY); end
      checks++; if (ack0 !== 1 || err0 !== 0) begin errors++; $display("[TB] FAIL retry_pulses: got ack=%0d err=%0d expected 1/0", ack0, err0); end
   endtask

   task automatic test_busy();
      bit ga, ge; logic [1:0] av, ev;
      do_reset();
      m_dly = 20; m_rty_n = 1000;
      req_adr[23:0] = 24'h000400; req_stb[0] = 1'b1;
      wait_done(0, 40000, ga, ge, av, ev);
      checks++; if (ge !== 1'b1 || ev !== 2'b01 || ga !== 1'b0) begin errors++; $display("[TB] FAIL busy_err: got ack=%b err=%b expected 0/01", ga, ev); end
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (windows !== 8) begin errors++; $display("[TB] FAIL busy_windows: got %0d expected 8", windows); end
      checks++; if (ack0 !== 0 || err0 !== 1) begin errors++; $display("[TB] FAIL busy_pulses: got ack=%0d err=%0d expected 0/1", ack0, err0); end
   endtask

   task automatic test_timeout();
      bit ga, ge; logic [1:0] av, ev;
      do_reset();
      m_silent = 1'b1;
      req_adr[23:0] = 24'h010000; req_we[0] = 1'b1; req_tga[0] = 1'b1; req_stb[0] = 1'b1;
      wait_done(0, 3000, ga, ge, av, ev);
      checks++; if (ge !== 1'b1 || ga !== 1'b0) begin errors++; $display("[TB] FAIL tmo_err: got ack=%b err=%b expected 0/1", ga, ge); end
      checks++; if (cap_we !== 1'b1 || cap_tga !== 1'b1) begin errors++; $display("[TB] FAIL tmo_erase: got we=%b tga=%b expected 1/1", cap_we, cap_tga); end
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (last_hi !== TMO || windows !== 1) begin errors++; $display("[TB] FAIL tmo_len: got hi=%0d win=%0d expected %0d/1", last_hi, windows, TMO); end
      checks++; if (req_dat_o !== 32'h0) begin errors++; $display("[TB] FAIL tmo_rdat: got %h expected 0", req_dat_o); end
      m_silent = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit up;
      do_reset();
      m_dly = 40; m_data = 32'h77778888;
      req_adr[23:0] = 24'h000500; req_stb[0] = 1'b1;
      up = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk_i);
         #1;
         if (stb_o) begin up = 1; break; end
      end
      checks++; if (up !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_bus: got %b expected 1", up); end
      repeat (10) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      checks++; if (stb_o !== 1'b0 || req_ack_o !== 2'b00 || req_err_o !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_drop: got stb=%b ack=%b err=%b expected 0/00/00", stb_o, req_ack_o, req_err_o); end
      rst_i = 1'b0;
      req_stb = '0;
      repeat (60) @(posedge clk_i);
      #1;
      checks++; if (ack0 !== 0 || err0 !== 0) begin errors++; $display("[TB] FAIL rstmid_pulses: got ack=%0d err=%0d expected 0/0", ack0, err0); end
   endtask

   task automatic test_abandon();
      bit fell;
      do_reset();
      m_dly = 40; m_data = 32'h0BADF00D;
      req_adr[47:24] = 24'h00ABCD; req_dat[63:32] = 32'h55AA55AA; req_we[1] = 1'b1; req_stb[1] = 1'b1;
      cap = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk_i);
         #1;
         if (stb_o) begin cap = 1; cap_adr = adr_o; cap_dat = dat_o; break; end
      end
      checks++; if (cap !== 1'b1 || cap_adr !== 24'h00ABCD || cap_dat !== 32'h55AA55AA) begin errors++; $display("[TB] FAIL abandon_bus: got up=%b adr=%h dat=%h expected 1/00abcd/55aa55aa", cap, cap_adr, cap_dat); end
      repeat (5) @(posedge clk_i);
      #1;
      req_stb[1] = 1'b0;
      fell = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk_i);
         #1;
         if (!stb_o) begin fell = 1; break; end
      end
      checks++; if (fell !== 1'b1) begin errors++; $display("[TB] FAIL abandon_end: got %b expected 1", fell); end
      repeat (30) @(posedge clk_i);
      #1;
      checks++; if (req_dat_o !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL abandon_done: got %h expected 0badf00d", req_dat_o); end
      checks++; if (ack1 !== 0 || err1 !== 0 || windows !== 1) begin errors++; $display("[TB] FAIL abandon_pulses: got ack=%0d err=%0d win=%0d expected 0/0/1", ack1, err1, windows); end
   endtask

   initial begin
      rst_i = 1'b1;
      req_stb = '0; req_we = '0; req_tga = '0; req_adr = '0; req_dat = '0;
      test_reset();
      test_read();
      test_rr();
      test_retry();
      test_busy();
      test_timeout();
      test_reset_mid();
      test_abandon();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
